// File: rtl/csr_pair_fetcher_if.sv
// Operand-pair stream from csr_pair_fetcher to row_accumulator.
// The master drives the pair and its row markers; the slave returns out_ready.
interface csr_pair_fetcher_if #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 8
);
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              out_first;
    logic              out_last;
    logic [ROW_W-1:0]  out_row;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output data_a, data_b, out_first, out_last, out_row, out_valid,
        input  out_ready
    );

    modport slave (
        input  data_a, data_b, out_first, out_last, out_row, out_valid,
        output out_ready
    );
endinterface

// File: rtl/csr_pair_fetcher.sv
// Walks a CSR sparse matrix held in ROMs and streams (value, x[col]) operand pairs,
// one row at a time with first/last markers, under valid/ready backpressure.
//
// state      | meaning
// IDLE       | waiting for start
// P0_WAIT    | row_ptr[0] on the bus, captured as the first row start
// PN_WAIT    | row_ptr[r+1] on the bus, captured as the row end
// NZ_WAIT    | col/val at nz_addr on the bus
// X_WAIT     | x[col] on the bus, pair is built
// EMIT       | pair presented, waiting for handshake
// EMPTY      | zero pair for an empty row presented, waiting for handshake
// NEXT_ROW   | advance row, end pointer becomes next row start
// FINISH     | done pulse, drop busy
module csr_pair_fetcher #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 8,
    parameter int NZ_W   = 12,
    parameter int COL_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ROW_W-1:0]  i_num_rows,
    output logic              o_busy,
    output logic              o_done,
    output logic [ROW_W-1:0]  o_ptr_addr,
    input  logic [NZ_W-1:0]   i_ptr_rdata,
    output logic [NZ_W-1:0]   o_nz_addr,
    input  logic [COL_W-1:0]  i_col_rdata,
    input  logic [DATA_W-1:0] i_val_rdata,
    output logic [COL_W-1:0]  o_x_addr,
    input  logic [DATA_W-1:0] i_x_rdata,
    csr_pair_fetcher_if.master pair
);

    typedef enum logic [3:0] {
        S_IDLE, S_P0_WAIT, S_PN_WAIT, S_NZ_WAIT, S_X_WAIT,
        S_EMIT, S_EMPTY, S_NEXT_ROW, S_FINISH
    } state_t;

    state_t             r_state;
    logic [ROW_W-1:0]   r_num_rows;
    logic [ROW_W-1:0]   r_row;
    logic [NZ_W-1:0]    r_k;
    logic [NZ_W-1:0]    r_end;
    logic [NZ_W-1:0]    r_row_start;
    logic [DATA_W-1:0]  r_val;
    logic               r_busy;
    logic               r_done;
    logic [ROW_W-1:0]   r_ptr_addr;
    logic [NZ_W-1:0]    r_nz_addr;
    logic [COL_W-1:0]   r_x_addr;
    logic [DATA_W-1:0]  r_data_a;
    logic [DATA_W-1:0]  r_data_b;
    logic               r_first;
    logic               r_last;
    logic [ROW_W-1:0]   r_out_row;
    logic               r_valid;

    logic               w_hs;
    logic [NZ_W-1:0]    w_k_next;
    logic [ROW_W-1:0]   w_row_next;

    assign w_hs       = r_valid && pair.out_ready;
    assign w_k_next   = r_k + NZ_W'(1);
    assign w_row_next = r_row + ROW_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_rows  <= '0;
            r_row       <= '0;
            r_k         <= '0;
            r_end       <= '0;
            r_row_start <= '0;
            r_val       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ptr_addr  <= '0;
            r_nz_addr   <= '0;
            r_x_addr    <= '0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_out_row   <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num_rows <= i_num_rows;
                        r_row      <= '0;
                        r_ptr_addr <= '0;
                        r_busy     <= 1'b1;
                        if (i_num_rows == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_P0_WAIT;
                        end
                    end
                end
                S_P0_WAIT: begin
                    r_k        <= i_ptr_rdata;
                    r_ptr_addr <= w_row_next;
                    r_state    <= S_PN_WAIT;
                end
                S_PN_WAIT: begin
                    r_end       <= i_ptr_rdata;
                    r_row_start <= r_k;
                    if (i_ptr_rdata == r_k) begin
                        r_data_a  <= '0;
                        r_data_b  <= '0;
                        r_first   <= 1'b1;
                        r_last    <= 1'b1;
                        r_out_row <= r_row;
                        r_valid   <= 1'b1;
                        r_state   <= S_EMPTY;
                    end else begin
                        r_nz_addr <= r_k;
                        r_state   <= S_NZ_WAIT;
                    end
                end
                S_NZ_WAIT: begin
                    r_val    <= i_val_rdata;
                    r_x_addr <= i_col_rdata;
                    r_state  <= S_X_WAIT;
                end
                S_X_WAIT: begin
                    r_data_a  <= r_val;
                    r_data_b  <= i_x_rdata;
                    r_first   <= (r_k == r_row_start);
                    r_last    <= (w_k_next == r_end);
                    r_out_row <= r_row;
                    r_valid   <= 1'b1;
                    r_state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_k     <= w_k_next;
                        if (r_last) begin
                            r_state <= S_NEXT_ROW;
                        end else begin
                            r_nz_addr <= w_k_next;
                            r_state   <= S_NZ_WAIT;
                        end
                    end
                end
                S_EMPTY: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_state <= S_NEXT_ROW;
                    end
                end
                S_NEXT_ROW: begin
                    // The end pointer of this row is the start of the next, so row_ptr is read once per row.
                    r_row <= w_row_next;
                    r_k   <= r_end;
                    if (w_row_next == r_num_rows) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_ptr_addr <= r_row + ROW_W'(2);
                        r_state    <= S_PN_WAIT;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_ptr_addr     = r_ptr_addr;
    assign o_nz_addr      = r_nz_addr;
    assign o_x_addr       = r_x_addr;
    assign pair.data_a    = r_data_a;
    assign pair.data_b    = r_data_b;
    assign pair.out_first = r_first;
    assign pair.out_last  = r_last;
    assign pair.out_row   = r_out_row;
    assign pair.out_valid = r_valid;

endmodule

// File: tb/tb_csr_pair_fetcher.sv
// Directed bench for csr_pair_fetcher: a CSR-level model builds the expected pair stream,
// and a negedge monitor compares every valid cycle against it.
module tb_csr_pair_fetcher;
    localparam int DATA_W = 32;
    localparam int ROW_W  = 8;
    localparam int NZ_W   = 12;
    localparam int COL_W  = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
        logic        l;
        logic [7:0]  row;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ROW_W-1:0]  num_rows;
    logic              busy;
    logic              done;
    logic [ROW_W-1:0]  ptr_addr;
    logic [NZ_W-1:0]   ptr_rdata;
    logic [NZ_W-1:0]   nz_addr;
    logic [COL_W-1:0]  col_rdata;
    logic [DATA_W-1:0] val_rdata;
    logic [COL_W-1:0]  x_addr;
    logic [DATA_W-1:0] x_rdata;

    logic [NZ_W-1:0]   rom_ptr [256];
    logic [COL_W-1:0]  rom_col [4096];
    logic [DATA_W-1:0] rom_val [4096];
    logic [DATA_W-1:0] mem_x   [256];

    pair_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_done   = 0;
    int    n_hs     = 0;
    int    cyc      = 0;
    int    last_hs  = -1;
    bit    mon_en   = 1'b0;
    bit    spacing_en = 1'b0;

    always #5 clk = ~clk;

    csr_pair_fetcher_if #(.DATA_W(DATA_W), .ROW_W(ROW_W)) pair_if ();

    csr_pair_fetcher #(.DATA_W(DATA_W), .ROW_W(ROW_W), .NZ_W(NZ_W), .COL_W(COL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_num_rows  (num_rows),
        .o_busy      (busy),
        .o_done      (done),
        .o_ptr_addr  (ptr_addr),
        .i_ptr_rdata (ptr_rdata),
        .o_nz_addr   (nz_addr),
        .i_col_rdata (col_rdata),
        .i_val_rdata (val_rdata),
        .o_x_addr    (x_addr),
        .i_x_rdata   (x_rdata),
        .pair        (pair_if)
    );

    assign ptr_rdata = rom_ptr[ptr_addr];
    assign col_rdata = rom_col[nz_addr];
    assign val_rdata = rom_val[nz_addr];
    assign x_rdata   = mem_x[x_addr];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected stream straight from CSR semantics: one zero pair per empty row, else one pair per nonzero.
    function automatic void build_model(input int nrows);
        pair_t p;
        exp_q.delete();
        for (int r = 0; r < nrows; r++) begin
            int s;
            int e;
            s = int'(rom_ptr[r]);
            e = int'(rom_ptr[r+1]);
            if (s == e) begin
                p.a = '0; p.b = '0; p.f = 1'b1; p.l = 1'b1; p.row = 8'(r);
                exp_q.push_back(p);
            end else begin
                for (int j = s; j < e; j++) begin
                    p.a   = rom_val[j];
                    p.b   = mem_x[rom_col[j]];
                    p.f   = (j == s);
                    p.l   = (j == e - 1);
                    p.row = 8'(r);
                    exp_q.push_back(p);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        pair_t act;
        cyc = cyc + 1;
        if (mon_en && !rst) begin
            if (pair_if.out_valid) begin
                act = {pair_if.data_a, pair_if.data_b, pair_if.out_first, pair_if.out_last, pair_if.out_row};
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 128'(act), 128'(0));
                end else begin
                    check("pair", 128'(act), 128'(exp_q[0]));
                    if (pair_if.out_ready) begin
                        void'(exp_q.pop_front());
                        n_hs++;
                        if (spacing_en && last_hs >= 0) check("pair_spacing", 128'(cyc - last_hs), 128'(3));
                        last_hs = cyc;
                    end
                end
            end
            if (done) begin
                n_done++;
                check("done_stream_complete", 128'(exp_q.size()), 128'(0));
            end
        end
    end

    task automatic load_basic();
        rom_ptr[0] = 12'd0; rom_ptr[1] = 12'd1; rom_ptr[2] = 12'd1; rom_ptr[3] = 12'd3;
        rom_col[0] = 8'd2;  rom_col[1] = 8'd0;  rom_col[2] = 8'd2;
        rom_val[0] = 32'd5; rom_val[1] = 32'd1; rom_val[2] = 32'd3;
        mem_x[0]   = 32'd2; mem_x[1]   = 32'd7; mem_x[2]   = 32'd4;
    endtask

    task automatic begin_test();
        n_done  = 0;
        n_hs    = 0;
        last_hs = -1;
    endtask

    task automatic pulse_start(input logic [ROW_W-1:0] n);
        num_rows = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic finish_run(input string name, input int budget, input int exp_pairs);
        int t;
        t = 0;
        while (n_done == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (n_done == 0) check({name, "_done_timeout"}, 128'(0), 128'(1));
        repeat (4) @(negedge clk);
        check({name, "_done_count"}, 128'(n_done), 128'(1));
        check({name, "_busy_after"}, 128'(busy), 128'(0));
        check({name, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
        check({name, "_pair_count"}, 128'(n_hs), 128'(exp_pairs));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin rom_ptr[i] = '0; mem_x[i] = '0; end
        for (int i = 0; i < 4096; i++) begin rom_col[i] = '0; rom_val[i] = '0; end
        rst = 1'b1; start = 1'b0; num_rows = '0;
        pair_if.out_ready = 1'b1;
        load_basic();
        repeat (3) @(negedge clk);
        check("reset_ctrl", 128'({busy, done, pair_if.out_valid}), 128'(0));
        check("reset_addr", 128'({ptr_addr, nz_addr, x_addr}), 128'(0));
        check("reset_pair", 128'({pair_if.data_a, pair_if.data_b, pair_if.out_first,
                                   pair_if.out_last, pair_if.out_row}), 128'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic 3x3 with ready held high; model pinned to hand-computed pairs.
        build_model(3);
        check("model_basic_len", 128'(exp_q.size()), 128'(4));
        check("model_basic_0", 128'(exp_q[0]), 128'({32'd5, 32'd4, 1'b1, 1'b1, 8'd0}));
        check("model_basic_1", 128'(exp_q[1]), 128'({32'd0, 32'd0, 1'b1, 1'b1, 8'd1}));
        check("model_basic_2", 128'(exp_q[2]), 128'({32'd1, 32'd2, 1'b1, 1'b0, 8'd2}));
        check("model_basic_3", 128'(exp_q[3]), 128'({32'd3, 32'd4, 1'b0, 1'b1, 8'd2}));
        begin_test();
        pulse_start(8'd3);
        check("busy_after_start", 128'(busy), 128'(1));
        finish_run("basic", 200, 4);

        // Backpressure on the first pair.
        build_model(3);
        begin_test();
        pair_if.out_ready = 1'b0;
        pulse_start(8'd3);
        begin
            int t;
            t = 0;
            while (!pair_if.out_valid && t < 50) begin @(negedge clk); t++; end
            if (!pair_if.out_valid) check("bp_valid_timeout", 128'(0), 128'(1));
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 128'({pair_if.out_valid, pair_if.data_a, pair_if.data_b,
                                    pair_if.out_first, pair_if.out_last}),
                  128'({1'b1, 32'd5, 32'd4, 1'b1, 1'b1}));
            @(negedge clk);
        end
        pair_if.out_ready = 1'b1;
        finish_run("backpressure", 200, 4);

        // num_rows = 0: no reads, no pairs, single done.
        do_reset();
        build_model(0);
        begin_test();
        pulse_start(8'd0);
        for (int i = 0; i < 4; i++) begin
            check("zero_rows_addr", 128'({ptr_addr, nz_addr, x_addr, pair_if.out_valid}), 128'(0));
            @(negedge clk);
        end
        finish_run("zero_rows", 50, 0);

        // Reset while the first pair of row 2 is valid.
        build_model(3);
        begin_test();
        pulse_start(8'd3);
        begin
            int t;
            t = 0;
            while (!(pair_if.out_valid && pair_if.out_row == 8'd2 && pair_if.out_first) && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) check("rst_mid_timeout", 128'(0), 128'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_state", 128'({pair_if.out_valid, busy, done}), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", 128'({done, busy}), 128'(0));
        build_model(3);
        begin_test();
        pulse_start(8'd3);
        finish_run("after_reset", 200, 4);

        // start pulsed mid-run is ignored.
        build_model(3);
        begin_test();
        pulse_start(8'd3);
        begin
            int t;
            t = 0;
            while (!(pair_if.out_valid && pair_if.out_row == 8'd1) && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) check("busy_start_timeout", 128'(0), 128'(1));
        end
        pulse_start(8'd1);
        num_rows = 8'd3;
        finish_run("start_while_busy", 200, 4);

        // Single full row: pairs back to back every 3 cycles.
        rom_ptr[0] = 12'd0; rom_ptr[1] = 12'd3;
        rom_col[0] = 8'd0;  rom_col[1] = 8'd1;  rom_col[2] = 8'd2;
        rom_val[0] = 32'd1; rom_val[1] = 32'd2; rom_val[2] = 32'd3;
        mem_x[0]   = 32'd4; mem_x[1]   = 32'd5; mem_x[2]   = 32'd6;
        build_model(1);
        check("model_full_len", 128'(exp_q.size()), 128'(3));
        check("model_full_0", 128'(exp_q[0]), 128'({32'd1, 32'd4, 1'b1, 1'b0, 8'd0}));
        check("model_full_1", 128'(exp_q[1]), 128'({32'd2, 32'd5, 1'b0, 1'b0, 8'd0}));
        check("model_full_2", 128'(exp_q[2]), 128'({32'd3, 32'd6, 1'b0, 1'b1, 8'd0}));
        begin_test();
        spacing_en = 1'b1;
        pulse_start(8'd1);
        finish_run("full_row", 100, 3);
        spacing_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csr_pair_fetcher.md
Name: csr_pair_fetcher

Overview:
- Upstream feeder for row_accumulator in the SMVM datapath.
- Walks a CSR-encoded sparse matrix held in synchronous ROMs (row pointers, column indices, values) and gathers matching dense-vector elements from x memory.
- Emits an ordered stream of (value, x[col]) operand pairs with row first/last markers, one row at a time, under valid/ready backpressure.

Parameters:
DATA_W, 32, width of matrix values and vector elements
ROW_W, 8, row index / row-pointer address width
NZ_W, 12, nonzero index width (row_ptr contents, col/val ROM address)
COL_W, 8, column index width (x memory address)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch traversal; sampled only in IDLE
num_rows  in  ROW_W  rows to process, latched on start; max 2^ROW_W-2
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after final pair handshakes
ptr_addr  out  ROW_W  row_ptr ROM address
ptr_rdata  in  NZ_W  row_ptr ROM data
nz_addr  out  NZ_W  shared address for col_idx and val ROMs
col_rdata  in  COL_W  col_idx ROM data
val_rdata  in  DATA_W  val ROM data
x_addr  out  COL_W  x memory address
x_rdata  in  DATA_W  x memory data
data_a  out  DATA_W  matrix value operand
data_b  out  DATA_W  vector operand
out_first  out  1  pair is first of its row (drives accumulator compute_start)
out_last  out  1  pair is last of its row
out_row  out  ROW_W  row index of pair
out_valid  out  1  pair valid
out_ready  in  1  downstream accepts pair

Behaviour:
- Memory model: every address output is registered; the corresponding rdata is valid exactly one cycle after the address is presented and is sampled in the following state.
- Reset: state=IDLE; all outputs 0, including addresses, busy, done, out_valid and out_* fields.
- Reset wins over all other events at any point, including mid-row and mid-handshake. The next cycle is IDLE with out_valid=0 and no done pulse.
- Row-pointer walk:
  - IDLE: on start, latch num_rows, clear row counter r, ptr_addr<=0, busy<=1. Go to P0_WAIT.
  - If num_rows=0: skip all reads and go to FINISH.
  - P0_WAIT: capture ptr_rdata as k (row start). ptr_addr<=r+1. Go to PN_WAIT.
  - PN_WAIT: capture ptr_rdata as end.
    - If end==k (empty row): go to EMPTY.
    - Else: nz_addr<=k, go to NZ_WAIT.
- Nonzero fetch:
  - NZ_WAIT: capture val_rdata, x_addr<=col_rdata. Go to X_WAIT.
  - X_WAIT: data_a<=held val, data_b<=x_rdata, out_valid<=1. Set out_first=(k==row start), out_last=(k+1==end), out_row=r. Go to EMIT.
  - EMIT: hold all out_* stable while out_valid && !out_ready. On handshake, out_valid<=0 and k<=k+1.
    - If not last: nz_addr<=k+1, go to NZ_WAIT.
    - If last: go to NEXT_ROW.
- EMPTY: present data_a=0, data_b=0, out_first=1, out_last=1, out_valid=1. Handshake as in EMIT, then go to NEXT_ROW. The accumulator therefore produces 0 for the row.
- NEXT_ROW: r<=r+1, k<=end.
  - If r+1==num_rows: go to FINISH.
  - Else: ptr_addr<=r+2, go to PN_WAIT. The start pointer is reused, so row_ptr is read once per row.
- FINISH: done=1 for one cycle, busy<=0, return to IDLE.
- Throughput: one pair per 3 cycles when out_ready is held high. No pipelining across pairs.
- start while busy is ignored.
- out_valid never drops without a handshake; data is never emitted out of CSR order.
- Widths: k and end are NZ_W unsigned. row_ptr is trusted monotonic; no range checking is performed.

Test Plan:
- Basic 3x3, ready=1:
  - Setup: row_ptr=[0,1,1,3], col=[2,0,2], val=[5,1,3], x=[2,7,4], num_rows=3, start pulse.
  - Required pairs, in order: (5,4,first,last,row0); (0,0,first,last,row1); (1,2,first,row2); (3,4,last,row2).
  - Then one done pulse, and busy=0 afterwards.
- Backpressure: same matrix, out_ready=0 for 5 cycles while the first pair is valid. data_a=5, data_b=4 and the flags must stay stable throughout; the stream then completes identically.
- num_rows=0: start → no out_valid; done pulses exactly once; no ROM address changes from reset value.
- Reset mid-row: assert rst while the row2 first pair is valid. Next cycle: out_valid=0, busy=0, no done pulse. A fresh start replays the full basic sequence.
- start during busy: pulse start during row1. The stream is unchanged and exactly one done pulse occurs.
- Full-row matrix: row_ptr=[0,3], col=[0,1,2], val=[1,2,3], x=[4,5,6]. Pairs (1,4,first),(2,5),(3,6,last). Pair spacing is 3 cycles with ready=1.
